// File: rtl/ppu_frame_writer.sv
// Turns the PPU pixel stream into framebuffer RAM writes. It handles double buffering, blank fill when
// the LCD is switched off, a frame-complete pulse and a sticky flag for dropped pixels.
module ppu_frame_writer #(
    parameter int H_ACTIVE    = 160,
    parameter int V_ACTIVE    = 144,
    parameter int PIXEL_BITS  = 2,
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 8,
    parameter int NUM_BUFFERS = 2,
    parameter int BLANK_VALUE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PIXEL_BITS-1:0]      ppu_pixel,
    input  logic                       ppu_valid,
    input  logic                       ppu_hblank,
    input  logic                       ppu_vblank,
    input  logic                       ppu_lcd_enable,
    input  logic                       clear_errors,
    output logic                       fb_write_en,
    output logic [Y_BITS+X_BITS:0]     fb_write_addr,
    output logic [PIXEL_BITS-1:0]      fb_write_data,
    output logic                       display_buffer,
    output logic                       frame_done,
    output logic                       overflow
);

    typedef enum logic [1:0] {ST_ACTIVE, ST_VBLANK, ST_FILL, ST_DISABLED} state_t;

    localparam logic [X_BITS:0]         LP_H      = (X_BITS+1)'(H_ACTIVE);
    localparam logic [Y_BITS:0]         LP_V      = (Y_BITS+1)'(V_ACTIVE);
    localparam logic [X_BITS-1:0]       LP_H_LAST = X_BITS'(H_ACTIVE - 1);
    localparam logic [Y_BITS-1:0]       LP_V_LAST = Y_BITS'(V_ACTIVE - 1);
    localparam logic [PIXEL_BITS-1:0]   LP_BLANK  = PIXEL_BITS'(BLANK_VALUE);
    localparam logic                    LP_WBUF0  = 1'(NUM_BUFFERS - 1);

    state_t                   r_state, w_state_nxt;
    logic [X_BITS-1:0]        r_x, w_x_nxt;
    logic [Y_BITS-1:0]        r_y, w_y_nxt;
    logic                     r_write_buf, w_wbuf_nxt;
    logic                     r_display_buf, w_dbuf_nxt;
    logic                     r_we, w_we_nxt;
    logic [Y_BITS+X_BITS:0]   r_addr, w_addr_nxt;
    logic [PIXEL_BITS-1:0]    r_data, w_data_nxt;
    logic                     r_frame_done, w_fd_nxt;
    logic                     r_overflow, w_drop;
    logic                     r_prev_hb, r_prev_vb, r_prev_lcd;

    logic w_hb_rise, w_vb_rise, w_vb_fall, w_lcd_rise, w_lcd_fall;
    logic w_in_range, w_buf_cur, w_fill_last;

    assign w_hb_rise   = ppu_hblank & ~r_prev_hb;
    assign w_vb_rise   = ppu_vblank & ~r_prev_vb;
    assign w_vb_fall   = ~ppu_vblank & r_prev_vb;
    assign w_lcd_rise  = ppu_lcd_enable & ~r_prev_lcd;
    assign w_lcd_fall  = ~ppu_lcd_enable & r_prev_lcd;
    assign w_in_range  = ({1'b0, r_x} < LP_H) && ({1'b0, r_y} < LP_V);
    assign w_buf_cur   = (NUM_BUFFERS == 2) ? r_write_buf : 1'b0;
    assign w_fill_last = (r_x == LP_H_LAST) && (r_y == LP_V_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_wbuf_nxt  = r_write_buf;
        w_dbuf_nxt  = r_display_buf;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_fd_nxt    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_ACTIVE: begin
                if (w_lcd_fall) begin
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_state_nxt = ST_FILL;
                end else begin
                    // The pixel is written at the old (x,y) before any line/frame advance below.
                    if (ppu_valid) begin
                        if (w_in_range) begin
                            w_we_nxt   = 1'b1;
                            w_addr_nxt = {w_buf_cur, r_y, r_x};
                            w_data_nxt = ppu_pixel;
                            w_x_nxt    = r_x + X_BITS'(1);
                        end else begin
                            w_drop = 1'b1;
                        end
                    end
                    if (w_vb_rise) begin
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                        w_fd_nxt    = 1'b1;
                        w_state_nxt = ST_VBLANK;
                        if (NUM_BUFFERS == 2) begin
                            w_dbuf_nxt = r_write_buf;
                            w_wbuf_nxt = ~r_write_buf;
                        end
                    end else if (w_hb_rise) begin
                        w_x_nxt = '0;
                        if ({1'b0, r_y} < LP_V) w_y_nxt = r_y + Y_BITS'(1);
                    end
                end
            end
            ST_VBLANK: begin
                if (w_lcd_fall) begin
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_state_nxt = ST_FILL;
                end else begin
                    w_drop = ppu_valid;
                    if (w_vb_fall) begin
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                        w_state_nxt = ST_ACTIVE;
                    end
                end
            end
            ST_FILL: begin
                w_we_nxt   = 1'b1;
                w_addr_nxt = {w_buf_cur, r_y, r_x};
                w_data_nxt = LP_BLANK;
                if (w_fill_last) begin
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_fd_nxt    = 1'b1;
                    w_state_nxt = ppu_lcd_enable ? ST_ACTIVE : ST_DISABLED;
                    if (NUM_BUFFERS == 2) begin
                        w_dbuf_nxt = r_write_buf;
                        w_wbuf_nxt = ~r_write_buf;
                    end
                end else if (r_x == LP_H_LAST) begin
                    w_x_nxt = '0;
                    w_y_nxt = r_y + Y_BITS'(1);
                end else begin
                    w_x_nxt = r_x + X_BITS'(1);
                end
            end
            ST_DISABLED: begin
                if (w_lcd_rise) begin
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_state_nxt = ST_ACTIVE;
                end
            end
            default: w_state_nxt = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_ACTIVE;
            r_x           <= '0;
            r_y           <= '0;
            r_write_buf   <= LP_WBUF0;
            r_display_buf <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_frame_done  <= 1'b0;
            r_overflow    <= 1'b0;
            r_prev_hb     <= 1'b0;
            r_prev_vb     <= 1'b0;
            r_prev_lcd    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_write_buf   <= w_wbuf_nxt;
            r_display_buf <= w_dbuf_nxt;
            r_we          <= w_we_nxt;
            r_addr        <= w_addr_nxt;
            r_data        <= w_data_nxt;
            r_frame_done  <= w_fd_nxt;
            r_overflow    <= (r_overflow & ~clear_errors) | w_drop;
            r_prev_hb     <= ppu_hblank;
            r_prev_vb     <= ppu_vblank;
            r_prev_lcd    <= ppu_lcd_enable;
        end
    end

    assign fb_write_en    = r_we;
    assign fb_write_addr  = r_addr;
    assign fb_write_data  = r_data;
    assign display_buffer = r_display_buf;
    assign frame_done     = r_frame_done;
    assign overflow       = r_overflow;

endmodule
